// File: rtl/med_pkg.sv
// med_pkg: shared state type, defaults and schedule helpers for the MED sequencer
package med_pkg;
  typedef enum logic [2:0] {COLLECT, FEED, SORT, CAPTURE, OUT} state_t;
  localparam int N_DEF = 7;
  localparam int SIZE_DEF = 9;
  localparam int PASSES = (SIZE_DEF - 1) / 2;
  localparam int CNT_W = $clog2(SIZE_DEF);
  function automatic int passes(input int size);
    return (size - 1) / 2;
  endfunction
  // cycles from the first FEED cycle to the end of SORT
  function automatic int sort_cycles(input int size);
    return size + passes(size) * size + size - 1;
  endfunction
endpackage

// File: rtl/med_win_buf.sv
// med_win_buf: SIZE-entry pixel window, written in order, read by index
module med_win_buf #(
  parameter int N = 7,
  parameter int SIZE = 9,
  parameter int CW = $clog2(SIZE)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          we,
  input  logic          clr,
  input  logic [N:0]    wdata,
  input  logic [CW-1:0] rd_idx,
  output logic [N:0]    rd_data,
  output logic          last
);
  logic [N:0] mem [SIZE];
  logic [CW-1:0] wcnt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) wcnt <= '0;
    else if (clr) wcnt <= '0;
    else if (we) wcnt <= wcnt + 1'b1;
  // pixel storage needs no reset: every entry is rewritten before it is read
  always_ff @(posedge CLK)
    if (we) mem[wcnt] <= wdata;
  assign rd_data = mem[rd_idx];
  assign last = wcnt == CW'(SIZE - 1);
endmodule

// File: rtl/med_seq.sv
// med_seq: collects a pixel window and drives the MED load/sort schedule, returning the median
module med_seq
  import med_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SIZE = SIZE_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [N:0] pix_i,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  output logic [N:0] med_di_o,
  output logic       med_dsi_o,
  output logic       med_byp_o,
  input  logic [N:0] med_do_i,
  output logic [N:0] median_o,
  output logic       median_valid_o,
  input  logic       median_ready_i,
  output logic       busy_o
);
  localparam int P = passes(SIZE);
  localparam int PH_W = $clog2(SIZE);
  localparam int PW = $clog2(P + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SIZE - 1);
  localparam logic [PH_W-1:0] PH_SORT_END = PH_W'(SIZE - 2);
  localparam logic [PW-1:0] PS_LAST = PW'(P);
  state_t state, nxt_state;
  logic [PH_W-1:0] phase, nxt_phase;
  logic [PW-1:0] pass, nxt_pass;
  logic accept, last;
  logic [N:0] rd_data;
  assign pix_ready_o = state == COLLECT;
  assign busy_o = !pix_ready_o;
  assign median_valid_o = state == OUT;
  assign accept = pix_valid_i & pix_ready_o;
  med_win_buf #(.N(N), .SIZE(SIZE)) u_buf (
    .CLK(CLK),
    .nRST(nRST),
    .we(accept),
    .clr(median_valid_o & median_ready_i),
    .wdata(pix_i),
    .rd_idx(nxt_phase),
    .rd_data(rd_data),
    .last(last)
  );
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_pass = pass;
    case (state)
      COLLECT: if (accept && last) begin
        nxt_state = FEED;
        nxt_phase = '0;
      end
      FEED: if (phase == PH_LAST) begin
        nxt_state = SORT;
        nxt_phase = '0;
        nxt_pass = '0;
      end else nxt_phase = phase + 1'b1;
      SORT: if (pass == PS_LAST && phase == PH_SORT_END) nxt_state = CAPTURE;
      else if (phase == PH_LAST) begin
        nxt_phase = '0;
        nxt_pass = pass + 1'b1;
      end else nxt_phase = phase + 1'b1;
      CAPTURE: nxt_state = OUT;
      OUT: if (median_ready_i) nxt_state = COLLECT;
      default: nxt_state = COLLECT;
    endcase
  end
  // MED controls are registered from the next state so they line up with the state cycle
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= COLLECT;
      phase <= '0;
      pass <= '0;
      med_dsi_o <= 1'b0;
      med_byp_o <= 1'b1;
      med_di_o <= '0;
      median_o <= '0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      pass <= nxt_pass;
      med_dsi_o <= nxt_state == FEED;
      med_byp_o <= !(nxt_state == SORT && nxt_phase != PH_LAST);
      med_di_o <= nxt_state == FEED ? rd_data : '0;
      if (state == CAPTURE) median_o <= med_do_i;
    end
endmodule

// File: tb/tb_med_seq.sv
// tb_med_seq: directed and random checks of med_seq driving a behavioural MED datapath
module tb_med_seq;
  logic CLK = 1'b0;
  logic nRST;
  logic [7:0] pix_i;
  logic pix_valid_i;
  logic pix_ready_o;
  logic [7:0] med_di_o;
  logic med_dsi_o;
  logic med_byp_o;
  logic [7:0] med_do_i;
  logic [7:0] median_o;
  logic median_valid_o;
  logic median_ready_i;
  logic busy_o;
  int checks = 0;
  int errors = 0;
  logic dsi_tr [200];
  logic byp_tr [200];
  logic rdy_tr [200];
  logic [7:0] di_tr [200];
  int busy_bad;

  always #5 CLK = ~CLK;

  med_seq #(.N(7), .SIZE(9)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .pix_i(pix_i),
    .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o),
    .med_di_o(med_di_o),
    .med_dsi_o(med_dsi_o),
    .med_byp_o(med_byp_o),
    .med_do_i(med_do_i),
    .median_o(median_o),
    .median_valid_o(median_valid_o),
    .median_ready_i(median_ready_i),
    .busy_o(busy_o)
  );

  // MED: shift chain r0..r7 with a max/min stage on r7/r8; BYP refills r0 with 0 so discarded maxima leave small fillers
  logic [7:0] r [9];
  logic [7:0] mx, mn;
  assign mx = r[7] > r[8] ? r[7] : r[8];
  assign mn = r[7] > r[8] ? r[8] : r[7];
  assign med_do_i = r[8];
  always @(posedge CLK) begin
    for (int i = 1; i < 8; i++) r[i] <= r[i-1];
    r[0] <= med_dsi_o ? med_di_o : (med_byp_o ? 8'd0 : mn);
    r[8] <= med_byp_o ? r[7] : mx;
  end

  function automatic logic [7:0] ref_med(input logic [7:0] w [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = w;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
    return s[4];
  endfunction

  function automatic logic exp_byp(input int c);
    return c <= 9 || c >= 54 || (c <= 45 && (c - 10) % 9 == 8);
  endfunction

  task automatic drive_window(input logic [7:0] w [9], input int maxgap);
    int g;
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        pix_valid_i = 1'b0;
        @(negedge CLK);
      end
      pix_i = w[i];
      pix_valid_i = 1'b1;
      g = 0;
      while (!pix_ready_o && g < 300) begin
        @(negedge CLK);
        g++;
      end
      checks++;
      if (pix_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL accept_timeout pixel=%0d ready=%b required 1", i, pix_ready_o);
      end
      @(negedge CLK);
    end
    pix_valid_i = 1'b0;
  endtask

  // lat counts cycles after the accept edge of the 9th pixel until median_valid_o is seen
  task automatic wait_median(output int lat);
    lat = 1;
    busy_bad = 0;
    while (!median_valid_o && lat < 199) begin
      dsi_tr[lat] = med_dsi_o;
      byp_tr[lat] = med_byp_o;
      di_tr[lat] = med_di_o;
      rdy_tr[lat] = pix_ready_o;
      if (busy_o === pix_ready_o) busy_bad++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset;
    nRST = 1'b1;
    pix_valid_i = 1'b0;
    pix_i = 8'd0;
    median_ready_i = 1'b1;
    #3 nRST = 1'b0;
    #4;
    checks++;
    if (pix_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", pix_ready_o); end
    checks++;
    if (med_dsi_o !== 1'b0) begin errors++; $display("FAIL reset_dsi got=%b exp=0", med_dsi_o); end
    checks++;
    if (med_byp_o !== 1'b1) begin errors++; $display("FAIL reset_byp got=%b exp=1", med_byp_o); end
    checks++;
    if (med_di_o !== 8'd0) begin errors++; $display("FAIL reset_di got=%0d exp=0", med_di_o); end
    checks++;
    if (median_o !== 8'd0) begin errors++; $display("FAIL reset_median got=%0d exp=0", median_o); end
    checks++;
    if (median_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", median_valid_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_descending;
    logic [7:0] w [9];
    int lat;
    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (lat !== 55) begin errors++; $display("FAIL desc_latency got=%0d exp=55", lat); end
    checks++;
    if (median_o !== 8'd5) begin errors++; $display("FAIL desc_median got=%0d exp=5", median_o); end
    @(negedge CLK);
    checks++;
    if (median_valid_o !== 1'b0) begin errors++; $display("FAIL desc_valid_pulse got=%b exp=0", median_valid_o); end
    checks++;
    if (pix_ready_o !== 1'b1) begin errors++; $display("FAIL desc_ready_after got=%b exp=1", pix_ready_o); end
  endtask

  task automatic test_gaps;
    logic [7:0] w [9];
    int lat, bd, bb, bi;
    w = '{8'd200, 8'd13, 8'd77, 8'd77, 8'd255, 8'd0, 8'd91, 8'd77, 8'd140};
    drive_window(w, 3);
    wait_median(lat);
    checks++;
    if (median_o !== 8'd77) begin errors++; $display("FAIL gaps_median got=%0d exp=77", median_o); end
    checks++;
    if (lat !== 55) begin errors++; $display("FAIL gaps_latency got=%0d exp=55", lat); end
    bd = 0;
    bb = 0;
    bi = 0;
    for (int c = 1; c < 55; c++) begin
      if (dsi_tr[c] !== (c <= 9)) bd++;
      if (byp_tr[c] !== exp_byp(c)) bb++;
      if (di_tr[c] !== (c <= 9 ? w[c-1] : 8'd0)) bi++;
    end
    checks++;
    if (bd !== 0) begin errors++; $display("FAIL gaps_dsi_pattern bad_cycles=%0d exp=0", bd); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL gaps_byp_pattern bad_cycles=%0d exp=0", bb); end
    checks++;
    if (bi !== 0) begin errors++; $display("FAIL gaps_di_pattern bad_cycles=%0d exp=0", bi); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [9];
    int lat, bad;
    w = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (median_o !== 8'hAA) begin errors++; $display("FAIL b2b_equal_median got=%0d exp=170", median_o); end
    w = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (median_o !== 8'd128) begin errors++; $display("FAIL b2b_second_median got=%0d exp=128", median_o); end
    bad = pix_ready_o ? 1 : 0;
    for (int c = 1; c < lat; c++) if (rdy_tr[c] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_ready_low bad_cycles=%0d exp=0", bad); end
    @(negedge CLK);
    checks++;
    if (pix_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got=%b exp=1", pix_ready_o); end
  endtask

  task automatic test_backpressure;
    logic [7:0] w [9];
    logic [7:0] held;
    int lat, bad;
    median_ready_i = 1'b0;
    w = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (median_valid_o !== 1'b1 || median_o !== 8'd4) begin
      errors++;
      $display("FAIL bp_median valid=%b got=%0d exp valid=1 median=4", median_valid_o, median_o);
    end
    held = median_o;
    pix_i = 8'h55;
    pix_valid_i = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (median_valid_o !== 1'b1 || median_o !== held || pix_ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    pix_valid_i = 1'b0;
    median_ready_i = 1'b1;
    @(negedge CLK);
    checks++;
    if (median_valid_o !== 1'b0 || pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b exp valid=0 ready=1", median_valid_o, pix_ready_o);
    end
    w = '{8'd10, 8'd90, 8'd20, 8'd80, 8'd30, 8'd70, 8'd40, 8'd60, 8'd50};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (median_o !== 8'd50) begin errors++; $display("FAIL bp_next_median got=%0d exp=50", median_o); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    logic [7:0] w [9];
    int lat;
    w = '{8'd90, 8'd10, 8'd80, 8'd20, 8'd70, 8'd30, 8'd60, 8'd40, 8'd50};
    drive_window(w, 0);
    repeat (30) @(negedge CLK);
    checks++;
    if (med_byp_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_sort byp=%b busy=%b exp byp=0 busy=1", med_byp_o, busy_o);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (pix_ready_o !== 1'b1 || busy_o !== 1'b0 || med_dsi_o !== 1'b0 || med_byp_o !== 1'b1 ||
        med_di_o !== 8'd0 || median_o !== 8'd0 || median_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs ready=%b busy=%b dsi=%b byp=%b di=%0d med=%0d valid=%b exp 1 0 0 1 0 0 0",
               pix_ready_o, busy_o, med_dsi_o, med_byp_o, med_di_o, median_o, median_valid_o);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    drive_window(w, 0);
    wait_median(lat);
    checks++;
    if (lat !== 55 || median_o !== 8'd5) begin
      errors++;
      $display("FAIL rmid_after latency=%0d median=%0d exp latency=55 median=5", lat, median_o);
    end
    @(negedge CLK);
  endtask

  task automatic test_random;
    logic [7:0] w [9];
    logic [7:0] e;
    int lat, tot_busy;
    tot_busy = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 9; i++) w[i] = (n % 4 == 0) ? 8'($urandom_range(3, 0)) : 8'($urandom_range(255, 0));
      e = ref_med(w);
      drive_window(w, 0);
      wait_median(lat);
      tot_busy += busy_bad;
      checks++;
      if (median_valid_o !== 1'b1 || median_o !== e) begin
        errors++;
        $display("FAIL rand_median window=%0d valid=%b got=%0d exp=%0d", n, median_valid_o, median_o, e);
      end
    end
    checks++;
    if (tot_busy !== 0) begin errors++; $display("FAIL rand_busy_vs_ready bad_cycles=%0d exp=0", tot_busy); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_descending;
    test_gaps;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
